// File: rtl/io_tx_bridge_pkg.sv
// Shared types and constants for the I/O word UART bridge.
// Holds TX state encoding, status bit positions and frame sizing.
package baej_io_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      PARITY
   } tx_state_t;

   localparam int STAT_OVF   = 15;
   localparam int STAT_FULL  = 14;
   localparam int STAT_EMPTY = 13;
   localparam int STAT_BUSY  = 12;

   localparam int DATA_BITS = 8;

endpackage

// File: rtl/io_tx_bridge_fifo.sv
// Circular word FIFO with same-cycle push/pop and a sticky overflow flag.
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module io_fifo #(
   parameter  int DEPTH = 8,
   parameter  int W     = 16,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_push,
   input  logic [W-1:0]  i_data,
   input  logic          i_pop,
   output logic [W-1:0]  o_data,
   output logic          o_full,
   output logic          o_empty,
   output logic [CW-1:0] o_count,
   output logic          o_overflow
);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [CW-1:0] r_count;
   logic          r_ovf;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_full     = (r_count == CW'(DEPTH));
   assign o_empty    = (r_count == '0);
   assign o_count    = r_count;
   assign o_overflow = r_ovf;
   assign o_data     = r_mem[r_rp];

   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk) begin
      if (w_do_push)
         r_mem[r_wp] <= i_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_do_push)
            r_wp <= r_wp + 1'b1;
         if (w_do_pop)
            r_rp <= r_rp + 1'b1;
         if (i_push && !w_do_push)
            r_ovf <= 1'b1;
         if (w_do_push && !w_do_pop)
            r_count <= r_count + 1'b1;
         else if (w_do_pop && !w_do_push)
            r_count <= r_count - 1'b1;
      end
   end

endmodule

// File: rtl/io_tx_bridge.sv
// Queues every change of the CPU I/O word and sends it as two UART frames.
// Define BAEJ_TX_PARITY_EN to add an even parity bit to each frame.
module io_tx_bridge
   import baej_io_pkg::*;
#(
   parameter int DEPTH        = 8,
   parameter int CLKS_PER_BIT = 434
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] io_out,
   output logic        tx,
   output logic [15:0] status,
   output logic        tx_busy
);

   localparam int CW   = $clog2(DEPTH + 1);
   localparam int CNTW = $clog2(CLKS_PER_BIT);
   localparam logic [CNTW-1:0] LAST = CNTW'(CLKS_PER_BIT - 1);
   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   tx_state_t       r_state;
   logic [15:0]     r_prev;
   logic [15:0]     r_shift;
   logic            r_byte_sel;
   logic [2:0]      r_bit;
   logic [CNTW-1:0] r_cnt;
   logic            r_tx;
   logic            r_busy;

   logic            w_push;
   logic            w_pop;
   logic [15:0]     w_head;
   logic            w_full;
   logic            w_empty;
   logic [CW-1:0]   w_count;
   logic            w_ovf;
   logic [7:0]      w_byte;
   logic            w_cnt_end;

   assign w_push    = (io_out != r_prev);
   assign w_pop     = (r_state == IDLE) && !w_empty;
   assign w_byte    = r_byte_sel ? r_shift[7:0] : r_shift[15:8];
   assign w_cnt_end = (r_cnt == LAST);

   io_fifo #(
      .DEPTH (DEPTH),
      .W     (16)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .i_push     (w_push),
      .i_data     (io_out),
      .i_pop      (w_pop),
      .o_data     (w_head),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_count    (w_count),
      .o_overflow (w_ovf)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_prev     <= io_out;
         r_shift    <= '0;
         r_byte_sel <= 1'b0;
         r_bit      <= '0;
         r_cnt      <= '0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
      end else begin
         if (w_push)
            r_prev <= io_out;
         unique case (r_state)
            IDLE: begin
               if (!w_empty) begin
                  r_shift    <= w_head;
                  r_byte_sel <= 1'b0;
                  r_cnt      <= '0;
                  r_tx       <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= START;
               end
            end
            START: begin
               if (w_cnt_end) begin
                  r_cnt   <= '0;
                  r_bit   <= '0;
                  r_tx    <= w_byte[0];
                  r_state <= DATA;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DATA: begin
               if (w_cnt_end) begin
                  r_cnt <= '0;
                  if (r_bit == LAST_BIT) begin
`ifdef BAEJ_TX_PARITY_EN
                     r_tx    <= ^w_byte;
                     r_state <= PARITY;
`else
                     r_tx    <= 1'b1;
                     r_state <= STOP;
`endif
                  end else begin
                     r_bit <= r_bit + 3'd1;
                     r_tx  <= w_byte[r_bit + 3'd1];
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
`ifdef BAEJ_TX_PARITY_EN
            PARITY: begin
               if (w_cnt_end) begin
                  r_cnt   <= '0;
                  r_tx    <= 1'b1;
                  r_state <= STOP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
`endif
            STOP: begin
               if (w_cnt_end) begin
                  r_cnt <= '0;
                  // second pass of the frame carries the low byte
                  if (!r_byte_sel) begin
                     r_byte_sel <= 1'b1;
                     r_tx       <= 1'b0;
                     r_state    <= START;
                  end else begin
                     r_busy  <= 1'b0;
                     r_state <= IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign tx      = r_tx;
   assign tx_busy = r_busy;

   always_comb begin
      status             = '0;
      status[STAT_OVF]   = w_ovf;
      status[STAT_FULL]  = w_full;
      status[STAT_EMPTY] = w_empty;
      status[STAT_BUSY]  = r_busy;
      status[3:0]        = 4'(w_count);
   end

endmodule

// File: tb/tb_io_tx_bridge.sv
// Random and directed stimulus for io_tx_bridge with a queue-based model
// and a UART decoder that checks every received word against a scoreboard.
module tb_io_tx_bridge;

   localparam int DEPTH = 8;
   localparam int CPB   = 4;
`ifdef BAEJ_TX_PARITY_EN
   localparam int NB = 11;
   localparam int WB = 22;
`else
   localparam int NB = 10;
   localparam int WB = 20;
`endif
   localparam int WCYC = WB * CPB;

   logic        clk;
   logic        reset;
   logic [15:0] io_out;
   logic        tx;
   logic [15:0] status;
   logic        tx_busy;

   io_tx_bridge #(
      .DEPTH        (DEPTH),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .io_out  (io_out),
      .tx      (tx),
      .status  (status),
      .tx_busy (tx_busy)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural model: FIFO contents, remaining cycles of the word on air
   logic [15:0] mq[$];
   logic [15:0] sb[$];
   int          m_busy = 0;
   logic [15:0] m_prev;
   bit          m_ovf  = 0;
   bit          m_rst  = 0;
   bit          m_init = 0;

   initial begin
      bit pop;
      bit acc;
      forever begin
         @(posedge clk);
         if (reset) begin
            mq.delete();
            sb.delete();
            m_busy = 0;
            m_ovf  = 0;
            m_prev = io_out;
            m_rst  = 1;
            m_init = 1;
         end else if (m_init) begin
            m_rst = 0;
            pop   = (m_busy == 0) && (mq.size() > 0);
            acc   = 0;
            if (m_busy > 0)
               m_busy--;
            if (io_out != m_prev) begin
               m_prev = io_out;
               if (mq.size() < DEPTH || pop)
                  acc = 1;
               else
                  m_ovf = 1;
            end
            if (pop) begin
               sb.push_back(mq.pop_front());
               m_busy = WCYC;
            end
            if (acc)
               mq.push_back(io_out);
         end
      end
   end

   // Per-cycle status and idle-line checks
   initial begin
      logic [15:0] es;
      forever begin
         @(negedge clk);
         if (m_init) begin
            es       = '0;
            es[15]   = m_ovf;
            es[14]   = (mq.size() == DEPTH);
            es[13]   = (mq.size() == 0);
            es[12]   = (m_busy > 0);
            es[3:0]  = 4'(mq.size());
            chk("status", 32'(status), 32'(es));
            chk("tx_busy", 32'(tx_busy), 32'(m_busy > 0));
            if (m_busy == 0)
               chk("tx_idle", 32'(tx), 32'd1);
         end
      end
   end

   // UART decoder sampling mid-bit, scoreboard compare per word
   int          words_rx = 0;
   bit          mon_act  = 0;
   int          mon_cyc  = 0;
   int          byte_idx = 0;
   logic [7:0]  hi_byte;
   initial begin
      logic [10:0] fb;
      logic [7:0]  by;
      int          k;
      fb = '0;
      forever begin
         @(negedge clk);
         if (!m_init || m_rst) begin
            mon_act  = 0;
            byte_idx = 0;
         end else if (mon_act) begin
            if (mon_cyc % CPB == CPB / 2) begin
               k     = mon_cyc / CPB;
               fb[k] = tx;
               if (k == NB - 1) begin
                  mon_act = 0;
                  by      = fb[8:1];
                  chk("start_bit", 32'(fb[0]), 32'd0);
`ifdef BAEJ_TX_PARITY_EN
                  chk("parity_bit", 32'(fb[9]), 32'(^by));
`endif
                  chk("stop_bit", 32'(fb[NB-1]), 32'd1);
                  if (byte_idx == 0) begin
                     hi_byte  = by;
                     byte_idx = 1;
                  end else begin
                     byte_idx = 0;
                     words_rx++;
                     if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_word: got %h want none",
                                 {hi_byte, by});
                     end else begin
                        chk("word", 32'({hi_byte, by}), 32'(sb.pop_front()));
                     end
                  end
               end
            end
            mon_cyc++;
         end else if (tx == 1'b0) begin
            mon_act = 1;
            mon_cyc = 1;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int n0;
      int lim;
      reset  = 1'b1;
      io_out = 16'hAAAA;
      step(2);
      reset = 1'b0;
      step(50);
      chk("reset_status", 32'(status), 32'h2000);
      chk("reset_tx", 32'(tx), 32'd1);
      chk("reset_no_frames", 32'(words_rx), 32'd0);

      reset  = 1'b1;
      io_out = 16'h0000;
      step(1);
      reset  = 1'b0;
      io_out = 16'h41C3;
      n0     = words_rx;
      step(1);
      chk("push_count", 32'(status), 32'h0001);
      step(WCYC);
      chk("still_busy", 32'(tx_busy), 32'd1);
      step(1);
      chk("word_done_status", 32'(status), 32'h2000);
      chk("word_done_busy", 32'(tx_busy), 32'd0);
      chk("word_41c3_rx", 32'(words_rx - n0), 32'd1);

      io_out = 16'h0700;
      n0     = words_rx;
      step(WCYC + 5);
      chk("word_0700_rx", 32'(words_rx - n0), 32'd1);

      io_out = 16'h1234;
      n0     = words_rx;
      step(100);
      chk("hold_one_word", 32'(words_rx - n0), 32'd1);

      n0 = words_rx;
      for (int i = 0; i < 9; i++) begin
         io_out = 16'hC000 | 16'(i << 8) | 16'($urandom_range(0, 255));
         step(1);
      end
      chk("fill_full", 32'(status[14]), 32'd1);
      chk("fill_count", 32'(status[3:0]), 32'd8);
      chk("fill_no_ovf", 32'(status[15]), 32'd0);
      io_out = 16'hEEEE;
      step(1);
      chk("ovf_set", 32'(status[15]), 32'd1);
      chk("ovf_count", 32'(status[3:0]), 32'd8);
      step(9 * (WCYC + 1) + 20);
      chk("ovf_words_rx", 32'(words_rx - n0), 32'd9);
      chk("ovf_sticky", 32'(status[15]), 32'd1);

      io_out = 16'h9876;
      step(8);
      reset = 1'b1;
      step(1);
      chk("midreset_tx", 32'(tx), 32'd1);
      chk("midreset_status", 32'(status), 32'h2000);
      reset = 1'b0;
      n0    = words_rx;
      step(100);
      chk("midreset_no_frames", 32'(words_rx - n0), 32'd0);

      for (int i = 0; i < 300; i++) begin
         io_out = 16'($urandom);
         if ($urandom_range(0, 3) == 0)
            step($urandom_range(1, 3));
         else
            step($urandom_range(1, 60));
      end

      lim = 0;
      while ((m_busy > 0 || mq.size() > 0) && lim < 20000) begin
         step(1);
         lim++;
      end
      chk("drain_timeout", 32'(lim < 20000), 32'd1);
      step(5);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      chk("decoder_idle", 32'(mon_act), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/io_tx_bridge.md
Name: io_tx_bridge

Overview:
Downstream consumer of the processor's 16-bit I/O output word. It captures every change on the datapath's I/O output into a small FIFO and serialises each word as two 8N1 UART frames on a single TX pin. It returns a 16-bit status word that the board top routes onto the processor's I/O input, so software can poll for space.

Parameters:
DEPTH, 8, FIFO entries; power of two, 2..8.
CLKS_PER_BIT, 434, clk cycles per UART bit; must be at least 2.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
io_out  input  16  processor I/O output word (datapath ioOut).
tx  output  1  UART serial out; idle high.
status  output  16  bit 15 overflow (sticky), bit 14 full, bit 13 empty, bit 12 tx_busy, bits 11:4 zero, bits 3:0 FIFO count.
tx_busy  output  1  high while a frame pair is in progress.

Behaviour:
- Reset (clk edge with reset=1):
  - tx=1, tx_busy=0, FIFO empty, count=0, overflow=0, FSM in IDLE.
  - prev_word loaded with io_out; no push occurs.
- Change detect:
  - Each cycle, if io_out != prev_word, push io_out and set prev_word=io_out.
  - Push is visible in count on the next cycle.
  - Repeated writes of the same value are NOT transmitted; this is a documented limitation.
- FIFO:
  - Circular, with read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH.
  - count ranges 0..DEPTH.
  - Push when full and no pop in the same cycle: word dropped, overflow set. Overflow clears only on reset.
  - Push and pop in the same cycle: both take effect. Count is unchanged, including when full, in which case nothing is dropped.
  - Pop when empty never happens.
- TX FSM states: IDLE, START, DATA, STOP. Also a byte_sel flag (0 = high byte) and a bit counter 0..7.
  - IDLE: if not empty, pop the head word into the shift holder, byte_sel=0, go to START on the next cycle. tx_busy rises the same cycle.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. If byte_sel=0, set byte_sel=1 and go to START (low byte); otherwise go to IDLE and drop tx_busy.
- Word order: high byte then low byte.
- Timing: one word occupies 20*CLKS_PER_BIT cycles of tx, plus 1 IDLE cycle before the next word.
- status is a registered output and reflects state after the current edge.
- Reset mid-frame: tx returns to 1 immediately on the reset edge, queued words are lost, and prev_word is reloaded.

Optional Feature:
Macro BAEJ_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles, so each word takes 22*CLKS_PER_BIT cycles.
- Undefined: plain 8N1 as above; the PARITY state and its logic are absent.

Decomposition:
- Package baej_io_pkg:
  - tx_state_t enum (IDLE, START, DATA, STOP, PARITY).
  - Status bit-position constants (STAT_OVF=15, STAT_FULL=14, STAT_EMPTY=13, STAT_BUSY=12).
  - UART frame constants (DATA_BITS=8).
- One sub-module, io_fifo, is natural: parameterised DEPTH, 16-bit, with push/pop, full/empty/count and same-cycle push+pop support.
- Change detect and the TX FSM stay in io_tx_bridge.

Test Plan:
- Reset with io_out=16'hAAAA, hold for 50 cycles -> tx stays 1, status=16'h2000 (empty, count 0), no frames.
- CLKS_PER_BIT=4; change io_out 16'h0000->16'h41C3 -> count=1 next cycle. tx shows start, 0x41 LSB-first, stop, start, 0xC3, stop, for 80 cycles total; tx_busy then falls and status returns to 16'h2000.
- Hold io_out at 16'h1234 for 100 cycles after one change -> exactly one word transmitted.
- With TX stalled mid-word, change io_out 9 times with DEPTH=8 (first change popped immediately) -> count reaches 8, status[14]=1. The 10th change sets status[15]=1, and the dropped word never appears on tx.
- Assert reset during the DATA state of the high byte -> tx=1 on that edge, status=16'h2000, no further frames.
- With BAEJ_TX_PARITY_EN defined, send 16'h0700 -> the high byte frame carries parity bit 1 and the low byte frame parity bit 0, for 88 cycles total at CLKS_PER_BIT=4.
